// File: rtl/mpu_common.sv
// Shared MPU types: ACT entry layout, lookup result/cause encodings and the
// lookup tag carried alongside an in-flight ACT read.
package mpu_common;

    localparam int MPU_ADDR_WIDTH     = 32;
    localparam int MPU_CORE_ID_WIDTH  = 3;
    localparam int MPU_MASK_WIDTH     = 1 << MPU_CORE_ID_WIDTH;
    localparam int MPU_PORT_IDX_WIDTH = 4;

    typedef enum logic {
        ACCESS_DENIED  = 1'b0,
        ACCESS_GRANTED = 1'b1
    } access_check_result_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_PERM    = 2'd1,
        CAUSE_INVALID = 2'd2,
        CAUSE_RANGE   = 2'd3
    } deny_cause_t;

    typedef struct packed {
        logic                      valid;
        logic [MPU_MASK_WIDTH-1:0] read_mask;
        logic [MPU_MASK_WIDTH-1:0] write_mask;
    } entry_t;

    typedef struct packed {
        logic [MPU_PORT_IDX_WIDTH-1:0] port;
        logic [MPU_CORE_ID_WIDTH-1:0]  core_id;
        logic [MPU_ADDR_WIDTH-1:0]     addr;
        logic                          we;
        logic                          oor;
    } check_tag_t;

    // Range beats validity beats permission; anything else is granted.
    function automatic deny_cause_t check_access(
        input logic                         oor,
        input logic                         we,
        input logic [MPU_CORE_ID_WIDTH-1:0] core_id,
        input entry_t                       entry
    );
        logic [MPU_MASK_WIDTH-1:0] mask;
        deny_cause_t               cause;
        mask = we ? entry.write_mask : entry.read_mask;
        if (oor)
            cause = CAUSE_RANGE;
        else if (!entry.valid)
            cause = CAUSE_INVALID;
        else if (!mask[core_id])
            cause = CAUSE_PERM;
        else
            cause = CAUSE_NONE;
        return cause;
    endfunction

endpackage

// File: rtl/access_check_mp_if.sv
// Requester-side bus of the access checker: per-port request and response
// handshakes packed into flat vectors, port p occupying slice p.
interface access_check_mp_if #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int CORE_ID_WIDTH = 3
);
    import mpu_common::*;

    logic [NUM_PORTS-1:0]                               req_valid;
    logic [NUM_PORTS-1:0]                               req_ready;
    logic [NUM_PORTS*CORE_ID_WIDTH-1:0]                 req_core_id;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]                    req_addr;
    logic [NUM_PORTS-1:0]                               req_we;
    logic [NUM_PORTS-1:0]                               rsp_valid;
    logic [NUM_PORTS-1:0]                               rsp_ready;
    logic [NUM_PORTS*$bits(access_check_result_t)-1:0]  rsp_result;
    logic [NUM_PORTS*$bits(deny_cause_t)-1:0]           rsp_cause;

    modport master (
        output req_valid, req_core_id, req_addr, req_we, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cause
    );

    modport slave (
        input  req_valid, req_core_id, req_addr, req_we, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cause
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer advances past the winner only when accept is strobed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_next   = PTR_W'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_reg <= '0;
        else if (accept)
            ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/access_check_mp.sv
// Multi-port pipelined MPU access checker: arbitrates requesters onto one ACT
// read port, decides GRANTED/DENIED per lookup and keeps a first-fault record.
module access_check_mp
    import mpu_common::*;
#(
    parameter int NUM_PORTS        = 2,
    parameter int ADDR_WIDTH       = MPU_ADDR_WIDTH,
    parameter int CORE_ID_WIDTH    = MPU_CORE_ID_WIDTH,
    parameter int REGION_SHIFT     = 12,
    parameter int BLOCK_COUNT_BITS = 8,
    parameter int ACT_LATENCY      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    access_check_mp_if.slave            bus,
    output logic                        act_cs,
    output logic [BLOCK_COUNT_BITS-1:0] act_addr,
    input  entry_t                      act_rdata,
    output logic                        fault_valid,
    output logic [CORE_ID_WIDTH-1:0]    fault_core,
    output logic [ADDR_WIDTH-1:0]       fault_addr,
    output logic                        fault_we,
    output deny_cause_t                 fault_cause,
    output logic                        fault_ovf,
    input  logic                        fault_clr
);

    localparam int PORT_W  = MPU_PORT_IDX_WIDTH;
    localparam int CAUSE_W = $bits(deny_cause_t);

    // ---------------- arbitration and accept ----------------
    logic [NUM_PORTS-1:0] busy_vec;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [NUM_PORTS-1:0] grant_q;
    logic                 accept;

    assign arb_req = bus.req_valid & ~busy_vec;
    // Ready is the grant itself, forced low while reset is held.
    assign grant_q       = rst ? '0 : arb_grant;
    assign bus.req_ready = grant_q;
    assign accept        = |grant_q;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (accept),
        .grant  (arb_grant)
    );

    logic [PORT_W-1:0]        win_port;
    logic [CORE_ID_WIDTH-1:0] win_core;
    logic [ADDR_WIDTH-1:0]    win_addr;
    logic                     win_we;
    logic [ADDR_WIDTH-1:0]    win_region;
    logic                     win_oor;

    always_comb begin
        win_port = '0;
        win_core = '0;
        win_addr = '0;
        win_we   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_grant[p]) begin
                win_port = PORT_W'(p);
                win_core = bus.req_core_id[p*CORE_ID_WIDTH +: CORE_ID_WIDTH];
                win_addr = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                win_we   = bus.req_we[p];
            end
        end
    end

    assign win_region = win_addr >> REGION_SHIFT;
    assign win_oor    = |(win_region >> BLOCK_COUNT_BITS);

    // ---------------- ACT strobe ----------------
    logic                        act_cs_reg;
    logic [BLOCK_COUNT_BITS-1:0] act_addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cs_reg   <= 1'b0;
            act_addr_reg <= '0;
        end else begin
            act_cs_reg <= accept && !win_oor;
            if (accept && !win_oor)
                act_addr_reg <= win_region[BLOCK_COUNT_BITS-1:0];
        end
    end

    assign act_cs   = act_cs_reg;
    assign act_addr = act_addr_reg;

    // ---------------- tag pipeline ----------------
    // Stage k holds the lookup issued k cycles ago; the last stage lines up
    // with act_rdata for that lookup.
    check_tag_t                 new_tag;
    check_tag_t                 tag_reg       [ACT_LATENCY+1];
    logic [ACT_LATENCY:0]       tag_valid_reg;

    always_comb begin
        new_tag         = '0;
        new_tag.port    = win_port;
        new_tag.core_id = win_core;
        new_tag.addr    = win_addr;
        new_tag.we      = win_we;
        new_tag.oor     = win_oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            for (int s = 0; s <= ACT_LATENCY; s++)
                tag_reg[s] <= '0;
        end else begin
            tag_valid_reg[0] <= accept;
            tag_reg[0]       <= new_tag;
            for (int s = 1; s <= ACT_LATENCY; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_reg[s]       <= tag_reg[s-1];
            end
        end
    end

    check_tag_t  done_tag;
    logic        done;
    deny_cause_t done_cause;
    logic        done_denied;

    assign done_tag    = tag_reg[ACT_LATENCY];
    assign done        = tag_valid_reg[ACT_LATENCY];
    assign done_cause  = check_access(done_tag.oor, done_tag.we, done_tag.core_id, act_rdata);
    assign done_denied = done && (done_cause != CAUSE_NONE);

    // ---------------- per-port credit and response ----------------
    logic [NUM_PORTS-1:0]         rsp_valid_vec;
    logic [NUM_PORTS-1:0]         rsp_result_vec;
    logic [NUM_PORTS*CAUSE_W-1:0] rsp_cause_vec;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic                 busy_reg;
        logic                 rsp_valid_reg;
        access_check_result_t rsp_result_reg;
        deny_cause_t          rsp_cause_reg;
        logic                 hit;
        logic                 handshake;

        assign hit       = done && (done_tag.port == PORT_W'(gi));
        assign handshake = rsp_valid_reg && bus.rsp_ready[gi];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_reg       <= 1'b0;
                rsp_valid_reg  <= 1'b0;
                rsp_result_reg <= ACCESS_DENIED;
                rsp_cause_reg  <= CAUSE_NONE;
            end else begin
                if (grant_q[gi])
                    busy_reg <= 1'b1;
                else if (handshake)
                    busy_reg <= 1'b0;

                // A port has one credit, so a completion never lands on a
                // response still waiting for its handshake.
                if (hit) begin
                    rsp_valid_reg  <= 1'b1;
                    rsp_result_reg <= (done_cause == CAUSE_NONE) ? ACCESS_GRANTED : ACCESS_DENIED;
                    rsp_cause_reg  <= done_cause;
                end else if (handshake) begin
                    rsp_valid_reg <= 1'b0;
                end
            end
        end

        assign busy_vec[gi]                       = busy_reg;
        assign rsp_valid_vec[gi]                  = rsp_valid_reg;
        assign rsp_result_vec[gi]                 = rsp_result_reg;
        assign rsp_cause_vec[gi*CAUSE_W +: CAUSE_W] = rsp_cause_reg;
    end

    assign bus.rsp_valid  = rsp_valid_vec;
    assign bus.rsp_result = rsp_result_vec;
    assign bus.rsp_cause  = rsp_cause_vec;

    // ---------------- sticky first-fault record ----------------
    logic                     fault_valid_reg;
    logic [CORE_ID_WIDTH-1:0] fault_core_reg;
    logic [ADDR_WIDTH-1:0]    fault_addr_reg;
    logic                     fault_we_reg;
    deny_cause_t              fault_cause_reg;
    logic                     fault_ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_valid_reg <= 1'b0;
            fault_core_reg  <= '0;
            fault_addr_reg  <= '0;
            fault_we_reg    <= 1'b0;
            fault_cause_reg <= CAUSE_NONE;
            fault_ovf_reg   <= 1'b0;
        end else begin
            if (fault_clr) begin
                fault_valid_reg <= 1'b0;
                fault_ovf_reg   <= 1'b0;
            end
            // A denial coinciding with a clear starts a fresh record.
            if (done_denied) begin
                if (fault_clr || !fault_valid_reg) begin
                    fault_valid_reg <= 1'b1;
                    fault_core_reg  <= done_tag.core_id;
                    fault_addr_reg  <= done_tag.addr;
                    fault_we_reg    <= done_tag.we;
                    fault_cause_reg <= done_cause;
                    fault_ovf_reg   <= 1'b0;
                end else begin
                    fault_ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign fault_valid = fault_valid_reg;
    assign fault_core  = fault_core_reg;
    assign fault_addr  = fault_addr_reg;
    assign fault_we    = fault_we_reg;
    assign fault_cause = fault_cause_reg;
    assign fault_ovf   = fault_ovf_reg;

endmodule
